// File: rtl/ram_stream_buffer.sv
// ram_stream_buffer
// Takes one read job (start row, row count, direction, first/last byte
// bounds), fetches the rows from SRAM in order under a credit limit, holds
// them in an ENT_NUM-deep circular buffer and streams them to the MXU.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ctrl_*                job request (valid/ready); ctrl_rdy means idle
//   ram_read_vld/addr/rdy SRAM row read request channel
//   ram_rsp_vld/data      SRAM read response, in request order
//   mxu_vld/data/byte_en/last/rdy  output beat stream to the MXU
//   busy                  job in progress
//   done                  one-cycle pulse after the final beat is taken
module ram_stream_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int ENT_NUM    = 16,
  parameter int CNT_WIDTH  = 5,
  parameter int BYTE_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ctrl_vld,
  output logic                    ctrl_rdy,
  input  logic [ADDR_WIDTH-1:0]   ctrl_start_addr,
  input  logic [CNT_WIDTH-1:0]    ctrl_ent_num,
  input  logic                    ctrl_dir,
  input  logic [BYTE_W-1:0]       ctrl_start_byte,
  input  logic [BYTE_W-1:0]       ctrl_end_byte,
  output logic                    ram_read_vld,
  output logic [ADDR_WIDTH-1:0]   ram_read_addr,
  input  logic                    ram_read_rdy,
  input  logic                    ram_rsp_vld,
  input  logic [DATA_WIDTH-1:0]   ram_rsp_data,
  output logic                    mxu_vld,
  output logic [DATA_WIDTH-1:0]   mxu_data,
  output logic [DATA_WIDTH/8-1:0] mxu_byte_en,
  output logic                    mxu_last,
  input  logic                    mxu_rdy,
  output logic                    busy,
  output logic                    done
);

  localparam int PTR_W  = $clog2(ENT_NUM);
  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] job_addr;
  logic [CNT_WIDTH-1:0]  job_num;
  logic                  job_dir;
  logic [BYTE_W-1:0]     job_start_byte;
  logic [BYTE_W-1:0]     job_end_byte;

  logic [CNT_WIDTH-1:0]  req_cnt;
  logic [CNT_WIDTH-1:0]  rsp_cnt;
  logic [CNT_WIDTH-1:0]  out_cnt;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] mem [ENT_NUM];

  logic                  accept;
  logic                  req_fire;
  logic                  push;
  logic                  pop;
  logic                  last_fire;
  logic                  final_req;
  logic                  is_first;
  logic                  is_last;
  logic [CNT_WIDTH-1:0]  outstanding;
  logic [CNT_WIDTH-1:0]  occupancy;
  logic [CNT_WIDTH:0]    inflight;
  logic                  credit_ok;

  // Byte b is enabled unless it lies before the start byte of the first
  // beat or after the end byte of the final beat.
  function automatic logic [NBYTES-1:0] byte_mask(input logic first,
                                                  input logic last,
                                                  input logic [BYTE_W-1:0] lo,
                                                  input logic [BYTE_W-1:0] hi);
    logic [NBYTES-1:0] m;
    logic [BYTE_W-1:0] idx;
    m = '0;
    for (int b = 0; b < NBYTES; b++) begin
      idx  = BYTE_W'(b);
      m[b] = (!first || (idx >= lo)) && (!last || (idx <= hi));
    end
    return m;
  endfunction

  assign ctrl_rdy = (state_q == IDLE);
  assign busy     = ~ctrl_rdy;
  assign done     = done_q;
  assign accept   = ctrl_vld & ctrl_rdy;

  // Counts restart at zero for every job, so the in-flight and buffered
  // row counts fall out as differences of the running counters.
  assign outstanding = req_cnt - rsp_cnt;
  assign occupancy   = rsp_cnt - out_cnt;
  assign inflight    = {1'b0, outstanding} + {1'b0, occupancy};
  assign credit_ok   = inflight < (CNT_WIDTH+1)'(ENT_NUM);

  assign ram_read_vld  = (state_q == FETCH) && (req_cnt < job_num) && credit_ok;
  assign ram_read_addr = job_dir ? (job_addr - ADDR_WIDTH'(req_cnt))
                                 : (job_addr + ADDR_WIDTH'(req_cnt));
  assign req_fire      = ram_read_vld & ram_read_rdy;
  assign final_req     = req_fire && ((req_cnt + CNT_WIDTH'(1)) == job_num);

  // A response with nothing outstanding (e.g. in flight across a reset)
  // is dropped rather than written into the buffer.
  assign push = ram_rsp_vld && (outstanding != '0);

  assign mxu_vld     = (occupancy != '0);
  assign mxu_data    = mem[rptr];
  assign is_first    = (out_cnt == '0);
  assign is_last     = (out_cnt == (job_num - CNT_WIDTH'(1)));
  assign mxu_last    = mxu_vld & is_last;
  assign mxu_byte_en = byte_mask(is_first, is_last, job_start_byte, job_end_byte);
  assign pop         = mxu_vld & mxu_rdy;
  assign last_fire   = pop & is_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (ctrl_ent_num != '0)) state_d = FETCH;
      FETCH:   if (final_req) state_d = DRAIN;
      DRAIN:   if (last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      job_addr       <= '0;
      job_num        <= '0;
      job_dir        <= 1'b0;
      job_start_byte <= '0;
      job_end_byte   <= '0;
      req_cnt        <= '0;
      rsp_cnt        <= '0;
      out_cnt        <= '0;
      wptr           <= '0;
      rptr           <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      // A zero-row job completes immediately on accept.
      done_q  <= last_fire || (accept && (ctrl_ent_num == '0));
      if (accept) begin
        job_addr       <= ctrl_start_addr;
        job_num        <= ctrl_ent_num;
        job_dir        <= ctrl_dir;
        job_start_byte <= ctrl_start_byte;
        job_end_byte   <= ctrl_end_byte;
        req_cnt        <= '0;
        rsp_cnt        <= '0;
        out_cnt        <= '0;
      end else begin
        if (req_fire) req_cnt <= req_cnt + CNT_WIDTH'(1);
        if (push)     rsp_cnt <= rsp_cnt + CNT_WIDTH'(1);
        if (pop)      out_cnt <= out_cnt + CNT_WIDTH'(1);
      end
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
    end
  end

  // Row storage carries data only and is left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= ram_rsp_data;
  end

endmodule

// File: tb/tb_ram_stream_buffer.sv
// Directed testbench for ram_stream_buffer with a latency-1 SRAM model and
// a negedge logger recording requests, beats and done pulses.
module tb_ram_stream_buffer;

  localparam int DW = 128;
  localparam int AW = 8;
  localparam int EN = 16;
  localparam int CW = 5;
  localparam int BW = 4;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ctrl_vld;
  logic          ctrl_rdy;
  logic [AW-1:0] ctrl_start_addr;
  logic [CW-1:0] ctrl_ent_num;
  logic          ctrl_dir;
  logic [BW-1:0] ctrl_start_byte;
  logic [BW-1:0] ctrl_end_byte;
  logic          ram_read_vld;
  logic [AW-1:0] ram_read_addr;
  logic          ram_read_rdy;
  logic          ram_rsp_vld = 1'b0;
  logic [DW-1:0] ram_rsp_data = '0;
  logic          mxu_vld;
  logic [DW-1:0] mxu_data;
  logic [NB-1:0] mxu_byte_en;
  logic          mxu_last;
  logic          mxu_rdy;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_stream_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ENT_NUM(EN), .CNT_WIDTH(CW), .BYTE_W(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_vld(ctrl_vld), .ctrl_rdy(ctrl_rdy),
    .ctrl_start_addr(ctrl_start_addr), .ctrl_ent_num(ctrl_ent_num),
    .ctrl_dir(ctrl_dir), .ctrl_start_byte(ctrl_start_byte),
    .ctrl_end_byte(ctrl_end_byte),
    .ram_read_vld(ram_read_vld), .ram_read_addr(ram_read_addr),
    .ram_read_rdy(ram_read_rdy),
    .ram_rsp_vld(ram_rsp_vld), .ram_rsp_data(ram_rsp_data),
    .mxu_vld(mxu_vld), .mxu_data(mxu_data), .mxu_byte_en(mxu_byte_en),
    .mxu_last(mxu_last), .mxu_rdy(mxu_rdy),
    .busy(busy), .done(done)
  );

  function automatic logic [DW-1:0] rowdata(input logic [AW-1:0] a);
    return {8{a, ~a}};
  endfunction

  // SRAM: answers every accepted request one cycle later.
  always @(posedge clk) begin
    ram_rsp_vld  <= ram_read_vld && ram_read_rdy;
    ram_rsp_data <= rowdata(ram_read_addr);
  end

  logic [AW-1:0] req_q[$];
  int            req_cyc_q[$];
  logic [DW-1:0] bd_q[$];
  logic [NB-1:0] be_q[$];
  logic          bl_q[$];
  int            beat_cyc_q[$];
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            acc_cyc = -1;
  int            outst = 0;

  // Handshakes seen here complete at the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      outst = 0;
    end else begin
      if (ram_rsp_vld) begin
        if (outst == 0) begin
          $display("FAIL sram_unsolicited_rsp got outstanding %0d want >0", outst);
          miscompares++;
        end else begin
          outst--;
        end
      end
      if (ram_read_vld && ram_read_rdy) begin
        req_q.push_back(ram_read_addr);
        req_cyc_q.push_back(cyc);
        outst++;
      end
      if (mxu_vld && mxu_rdy) begin
        bd_q.push_back(mxu_data);
        be_q.push_back(mxu_byte_en);
        bl_q.push_back(mxu_last);
        beat_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ctrl_vld && ctrl_rdy) acc_cyc = cyc;
    end
  end

  task automatic clear_log();
    req_q.delete(); req_cyc_q.delete();
    bd_q.delete(); be_q.delete(); bl_q.delete(); beat_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; acc_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] addr, input int num, input logic dir,
                           input int sb, input int eb);
    int n = 0;
    @(posedge clk); #1;
    while (!ctrl_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ctrl_start_addr = addr;
    ctrl_ent_num    = CW'(num);
    ctrl_dir        = dir;
    ctrl_start_byte = BW'(sb);
    ctrl_end_byte   = BW'(eb);
    ctrl_vld        = 1'b1;
    @(posedge clk); #1;
    ctrl_vld        = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (ctrl_rdy !== 1'b1) begin $display("FAIL rst_ctrl_rdy got %b want 1", ctrl_rdy); miscompares++; end
    vectors++; if (busy !== 1'b0) begin $display("FAIL rst_busy got %b want 0", busy); miscompares++; end
    vectors++; if (done !== 1'b0) begin $display("FAIL rst_done got %b want 0", done); miscompares++; end
    vectors++; if (ram_read_vld !== 1'b0) begin $display("FAIL rst_ram_read_vld got %b want 0", ram_read_vld); miscompares++; end
    vectors++; if (mxu_vld !== 1'b0) begin $display("FAIL rst_mxu_vld got %b want 0", mxu_vld); miscompares++; end
    vectors++; if (mxu_last !== 1'b0) begin $display("FAIL rst_mxu_last got %b want 0", mxu_last); miscompares++; end
  endtask

  task automatic test_ascending();
    logic ok;
    logic [AW-1:0] a;
    logic [NB-1:0] exp_be [4] = '{16'hFFF8, 16'hFFFF, 16'hFFFF, 16'h1FFF};
    clear_log();
    mxu_rdy = 1'b1;
    start_job(8'h10, 4, 1'b0, 3, 12);
    wait_done(60, ok);
    vectors++; if (ok !== 1'b1) begin $display("FAIL asc_done_timeout got %b want 1", ok); miscompares++; end
    vectors++; if (req_q.size() !== 4) begin $display("FAIL asc_req_count got %0d want 4", req_q.size()); miscompares++; end
    vectors++; if (bd_q.size() !== 4) begin $display("FAIL asc_beat_count got %0d want 4", bd_q.size()); miscompares++; end
    for (int i = 0; i < 4; i++) begin
      a = 8'h10 + AW'(i);
      vectors++; if (req_q[i] !== a) begin $display("FAIL asc_addr[%0d] got %h want %h", i, req_q[i], a); miscompares++; end
      vectors++; if (req_cyc_q[i] !== acc_cyc + 1 + i) begin $display("FAIL asc_req_cycle[%0d] got %0d want %0d", i, req_cyc_q[i], acc_cyc + 1 + i); miscompares++; end
      vectors++; if (bd_q[i] !== rowdata(a)) begin $display("FAIL asc_data[%0d] got %h want %h", i, bd_q[i], rowdata(a)); miscompares++; end
      vectors++; if (be_q[i] !== exp_be[i]) begin $display("FAIL asc_byte_en[%0d] got %h want %h", i, be_q[i], exp_be[i]); miscompares++; end
      vectors++; if (bl_q[i] !== (i == 3)) begin $display("FAIL asc_last[%0d] got %b want %b", i, bl_q[i], (i == 3)); miscompares++; end
    end
    vectors++; if (beat_cyc_q[0] !== req_cyc_q[0] + 2) begin $display("FAIL asc_first_beat_cycle got %0d want %0d", beat_cyc_q[0], req_cyc_q[0] + 2); miscompares++; end
    vectors++; if (done_cyc !== beat_cyc_q[3] + 1) begin $display("FAIL asc_done_cycle got %0d want %0d", done_cyc, beat_cyc_q[3] + 1); miscompares++; end
    vectors++; if (done_cnt !== 1) begin $display("FAIL asc_done_count got %0d want 1", done_cnt); miscompares++; end
  endtask

  task automatic test_descending();
    logic ok;
    logic [AW-1:0] exp_a [3] = '{8'h01, 8'h00, 8'hFF};
    clear_log();
    mxu_rdy = 1'b1;
    start_job(8'h01, 3, 1'b1, 0, 15);
    wait_done(60, ok);
    vectors++; if (ok !== 1'b1) begin $display("FAIL desc_done_timeout got %b want 1", ok); miscompares++; end
    vectors++; if (req_q.size() !== 3) begin $display("FAIL desc_req_count got %0d want 3", req_q.size()); miscompares++; end
    vectors++; if (bd_q.size() !== 3) begin $display("FAIL desc_beat_count got %0d want 3", bd_q.size()); miscompares++; end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (req_q[i] !== exp_a[i]) begin $display("FAIL desc_addr[%0d] got %h want %h", i, req_q[i], exp_a[i]); miscompares++; end
      vectors++; if (bd_q[i] !== rowdata(exp_a[i])) begin $display("FAIL desc_data[%0d] got %h want %h", i, bd_q[i], rowdata(exp_a[i])); miscompares++; end
      vectors++; if (be_q[i] !== 16'hFFFF) begin $display("FAIL desc_byte_en[%0d] got %h want ffff", i, be_q[i]); miscompares++; end
      vectors++; if (bl_q[i] !== (i == 2)) begin $display("FAIL desc_last[%0d] got %b want %b", i, bl_q[i], (i == 2)); miscompares++; end
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    logic [AW-1:0] a;
    clear_log();
    mxu_rdy = 1'b0;
    start_job(8'h40, 16, 1'b0, 0, 15);
    idle(10);
    // A request while busy must be ignored.
    ctrl_start_addr = 8'h99; ctrl_ent_num = CW'(2); ctrl_vld = 1'b1;
    idle(1);
    ctrl_vld = 1'b0;
    idle(19);
    vectors++; if (req_q.size() !== 16) begin $display("FAIL bp_req_count got %0d want 16", req_q.size()); miscompares++; end
    vectors++; if (ram_read_vld !== 1'b0) begin $display("FAIL bp_read_vld_stalled got %b want 0", ram_read_vld); miscompares++; end
    vectors++; if (bd_q.size() !== 0) begin $display("FAIL bp_beats_while_stalled got %0d want 0", bd_q.size()); miscompares++; end
    vectors++; if (mxu_vld !== 1'b1) begin $display("FAIL bp_mxu_vld got %b want 1", mxu_vld); miscompares++; end
    vectors++; if (busy !== 1'b1) begin $display("FAIL bp_busy got %b want 1", busy); miscompares++; end
    mxu_rdy = 1'b1;
    wait_done(80, ok);
    vectors++; if (ok !== 1'b1) begin $display("FAIL bp_done_timeout got %b want 1", ok); miscompares++; end
    vectors++; if (bd_q.size() !== 16) begin $display("FAIL bp_beat_count got %0d want 16", bd_q.size()); miscompares++; end
    vectors++; if (req_q.size() !== 16) begin $display("FAIL bp_req_total got %0d want 16", req_q.size()); miscompares++; end
    for (int i = 0; i < 16; i++) begin
      a = 8'h40 + AW'(i);
      vectors++; if (bd_q[i] !== rowdata(a)) begin $display("FAIL bp_data[%0d] got %h want %h", i, bd_q[i], rowdata(a)); miscompares++; end
      vectors++; if (bl_q[i] !== (i == 15)) begin $display("FAIL bp_last[%0d] got %b want %b", i, bl_q[i], (i == 15)); miscompares++; end
    end
    vectors++; if (done_cnt !== 1) begin $display("FAIL bp_done_count got %0d want 1", done_cnt); miscompares++; end
  endtask

  task automatic test_credit();
    logic ok;
    logic [AW-1:0] a;
    logic [NB-1:0] eb;
    clear_log();
    mxu_rdy = 1'b0;
    start_job(8'hF8, 20, 1'b0, 2, 9);
    idle(30);
    vectors++; if (req_q.size() !== 16) begin $display("FAIL cr_req_stall got %0d want 16", req_q.size()); miscompares++; end
    vectors++; if (ram_read_vld !== 1'b0) begin $display("FAIL cr_read_vld_stall got %b want 0", ram_read_vld); miscompares++; end
    mxu_rdy = 1'b1;
    idle(1);
    mxu_rdy = 1'b0;
    idle(5);
    vectors++; if (bd_q.size() !== 1) begin $display("FAIL cr_single_pop got %0d want 1", bd_q.size()); miscompares++; end
    vectors++; if (req_q.size() !== 17) begin $display("FAIL cr_req_after_pop got %0d want 17", req_q.size()); miscompares++; end
    vectors++; if (req_cyc_q[16] !== beat_cyc_q[0] + 1) begin $display("FAIL cr_resume_cycle got %0d want %0d", req_cyc_q[16], beat_cyc_q[0] + 1); miscompares++; end
    vectors++; if (ram_read_vld !== 1'b0) begin $display("FAIL cr_read_vld_restall got %b want 0", ram_read_vld); miscompares++; end
    mxu_rdy = 1'b1;
    wait_done(100, ok);
    vectors++; if (ok !== 1'b1) begin $display("FAIL cr_done_timeout got %b want 1", ok); miscompares++; end
    vectors++; if (req_q.size() !== 20) begin $display("FAIL cr_req_count got %0d want 20", req_q.size()); miscompares++; end
    vectors++; if (bd_q.size() !== 20) begin $display("FAIL cr_beat_count got %0d want 20", bd_q.size()); miscompares++; end
    for (int i = 0; i < 20; i++) begin
      a  = 8'hF8 + AW'(i);
      eb = (i == 0) ? 16'hFFFC : ((i == 19) ? 16'h03FF : 16'hFFFF);
      vectors++; if (req_q[i] !== a) begin $display("FAIL cr_addr[%0d] got %h want %h", i, req_q[i], a); miscompares++; end
      vectors++; if (bd_q[i] !== rowdata(a)) begin $display("FAIL cr_data[%0d] got %h want %h", i, bd_q[i], rowdata(a)); miscompares++; end
      vectors++; if (be_q[i] !== eb) begin $display("FAIL cr_byte_en[%0d] got %h want %h", i, be_q[i], eb); miscompares++; end
      vectors++; if (bl_q[i] !== (i == 19)) begin $display("FAIL cr_last[%0d] got %b want %b", i, bl_q[i], (i == 19)); miscompares++; end
    end
    vectors++; if (done_cnt !== 1) begin $display("FAIL cr_done_count got %0d want 1", done_cnt); miscompares++; end
  endtask

  task automatic test_edge_jobs();
    logic ok;
    clear_log();
    mxu_rdy = 1'b1;
    start_job(8'h55, 0, 1'b0, 0, 0);
    wait_done(10, ok);
    vectors++; if (ok !== 1'b1) begin $display("FAIL zero_done_timeout got %b want 1", ok); miscompares++; end
    vectors++; if (done_cyc !== acc_cyc + 1) begin $display("FAIL zero_done_cycle got %0d want %0d", done_cyc, acc_cyc + 1); miscompares++; end
    vectors++; if (req_q.size() !== 0) begin $display("FAIL zero_req_count got %0d want 0", req_q.size()); miscompares++; end
    vectors++; if (bd_q.size() !== 0) begin $display("FAIL zero_beat_count got %0d want 0", bd_q.size()); miscompares++; end
    vectors++; if (done_cnt !== 1) begin $display("FAIL zero_done_count got %0d want 1", done_cnt); miscompares++; end

    clear_log();
    start_job(8'h22, 1, 1'b0, 5, 5);
    wait_done(20, ok);
    vectors++; if (ok !== 1'b1) begin $display("FAIL one_done_timeout got %b want 1", ok); miscompares++; end
    vectors++; if (bd_q.size() !== 1) begin $display("FAIL one_beat_count got %0d want 1", bd_q.size()); miscompares++; end
    vectors++; if (be_q[0] !== 16'h0020) begin $display("FAIL one_byte_en got %h want 0020", be_q[0]); miscompares++; end
    vectors++; if (bl_q[0] !== 1'b1) begin $display("FAIL one_last got %b want 1", bl_q[0]); miscompares++; end
    vectors++; if (bd_q[0] !== rowdata(8'h22)) begin $display("FAIL one_data got %h want %h", bd_q[0], rowdata(8'h22)); miscompares++; end

    clear_log();
    start_job(8'h23, 1, 1'b0, 9, 3);
    wait_done(20, ok);
    vectors++; if (ok !== 1'b1) begin $display("FAIL inv_done_timeout got %b want 1", ok); miscompares++; end
    vectors++; if (bd_q.size() !== 1) begin $display("FAIL inv_beat_count got %0d want 1", bd_q.size()); miscompares++; end
    vectors++; if (be_q[0] !== 16'h0000) begin $display("FAIL inv_byte_en got %h want 0000", be_q[0]); miscompares++; end
    vectors++; if (bl_q[0] !== 1'b1) begin $display("FAIL inv_last got %b want 1", bl_q[0]); miscompares++; end
  endtask

  task automatic test_reset_mid_fetch();
    logic ok;
    logic reached = 1'b0;
    logic [AW-1:0] a;
    clear_log();
    mxu_rdy = 1'b1;
    start_job(8'h80, 8, 1'b0, 0, 15);
    for (int n = 0; n < 20; n++) begin
      if (req_q.size() >= 2) begin
        reached = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    vectors++; if (reached !== 1'b1) begin $display("FAIL rmid_two_reqs_timeout got %0d want 2", req_q.size()); miscompares++; end
    rst_n = 1'b0;
    #1;
    vectors++; if (ctrl_rdy !== 1'b1) begin $display("FAIL rmid_ctrl_rdy got %b want 1", ctrl_rdy); miscompares++; end
    vectors++; if (busy !== 1'b0) begin $display("FAIL rmid_busy got %b want 0", busy); miscompares++; end
    vectors++; if (ram_read_vld !== 1'b0) begin $display("FAIL rmid_read_vld got %b want 0", ram_read_vld); miscompares++; end
    vectors++; if (mxu_vld !== 1'b0) begin $display("FAIL rmid_mxu_vld got %b want 0", mxu_vld); miscompares++; end
    vectors++; if (mxu_last !== 1'b0) begin $display("FAIL rmid_mxu_last got %b want 0", mxu_last); miscompares++; end
    vectors++; if (done !== 1'b0) begin $display("FAIL rmid_done got %b want 0", done); miscompares++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    vectors++; if (mxu_vld !== 1'b0) begin $display("FAIL rmid_stale_vld got %b want 0", mxu_vld); miscompares++; end

    clear_log();
    start_job(8'h30, 3, 1'b0, 0, 15);
    wait_done(40, ok);
    vectors++; if (ok !== 1'b1) begin $display("FAIL rmid_done_timeout got %b want 1", ok); miscompares++; end
    vectors++; if (req_q.size() !== 3) begin $display("FAIL rmid_req_count got %0d want 3", req_q.size()); miscompares++; end
    vectors++; if (bd_q.size() !== 3) begin $display("FAIL rmid_beat_count got %0d want 3", bd_q.size()); miscompares++; end
    for (int i = 0; i < 3; i++) begin
      a = 8'h30 + AW'(i);
      vectors++; if (bd_q[i] !== rowdata(a)) begin $display("FAIL rmid_data[%0d] got %h want %h", i, bd_q[i], rowdata(a)); miscompares++; end
      vectors++; if (bl_q[i] !== (i == 2)) begin $display("FAIL rmid_last[%0d] got %b want %b", i, bl_q[i], (i == 2)); miscompares++; end
    end
    vectors++; if (done_cnt !== 1) begin $display("FAIL rmid_done_count got %0d want 1", done_cnt); miscompares++; end
  endtask

  initial begin
    rst_n           = 1'b0;
    ctrl_vld        = 1'b0;
    ctrl_start_addr = '0;
    ctrl_ent_num    = '0;
    ctrl_dir        = 1'b0;
    ctrl_start_byte = '0;
    ctrl_end_byte   = '0;
    ram_read_rdy    = 1'b1;
    mxu_rdy         = 1'b0;
    test_reset();
    test_ascending();
    test_descending();
    test_backpressure();
    test_credit();
    test_edge_jobs();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
